// File: rtl/mem_ctrl.sv
// Memory-side responder for the icache (port 1) and dcache (port 0): round-robin arbitration,
// each 32-bit word access split into four byte accesses to an 8-bit synchronous RAM.
module mem_ctrl #(
    parameter int ADDR_W  = 17,
    parameter int PORTS_N = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*PORTS_N-1:0]  rw_flag_i,
    input  logic [32*PORTS_N-1:0] addr_i,
    input  logic [32*PORTS_N-1:0] w_data_i,
    input  logic [4*PORTS_N-1:0]  w_mask_i,
    output logic [32*PORTS_N-1:0] r_data_o,
    output logic [PORTS_N-1:0]    busy_o,
    output logic [PORTS_N-1:0]    done_o,
    output logic [ADDR_W-1:0]     ram_addr_o,
    output logic                  ram_we_o,
    output logic [7:0]            ram_wdata_o,
    input  logic [7:0]            ram_rdata_i
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_TAIL,
        WR,
        DONE
    } state_t;

    state_t              state;
    logic [1:0]          cnt;
    logic                ptr;
    logic                gnt;
    logic [ADDR_W-3:0]   word;
    logic [31:0]         wdata;
    logic [3:0]          wmask;
    logic [23:0]         rbuf;

    logic [PORTS_N-1:0]  pend;
    logic                sel;
    logic [1:0]          sel_flag;
    logic [31:0]         sel_addr;
    logic [31:0]         sel_wdata;
    logic [3:0]          sel_mask;
    logic [1:0]          cnt_inc;
    logic                unused_addr_bits;

    always_comb begin
        pend = '0;
        for (int p = 0; p < PORTS_N; p++) begin
            pend[p] = |rw_flag_i[2*p +: 2];
        end
    end

    // A lone requester is granted directly; a tie goes to the pointer's port.
    always_comb begin
        sel = ptr;
        if (pend == 2'b01) begin
            sel = 1'b0;
        end else if (pend == 2'b10) begin
            sel = 1'b1;
        end
    end

    assign sel_flag  = rw_flag_i[2*sel +: 2];
    assign sel_addr  = addr_i[32*sel +: 32];
    assign sel_wdata = w_data_i[32*sel +: 32];
    assign sel_mask  = w_mask_i[4*sel +: 4];
    assign cnt_inc   = cnt + 2'd1;

    // Byte-lane bits and bits above the RAM width do not take part in addressing.
    assign unused_addr_bits = ^{sel_addr[31:ADDR_W], sel_addr[1:0]};

    // NOTE: every register below is state, so it is assigned with <= only; the
    // reset branch is synchronous and covers all of them, including the read buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            ptr         <= 1'b0;
            gnt         <= 1'b0;
            word        <= '0;
            wdata       <= '0;
            wmask       <= '0;
            rbuf        <= '0;
            r_data_o    <= '0;
            busy_o      <= '0;
            done_o      <= '0;
            ram_addr_o  <= '0;
            ram_we_o    <= 1'b0;
            ram_wdata_o <= '0;
        end else begin
            // NOTE: done_o defaults low every cycle so the state that sets it yields a single-cycle pulse.
            done_o <= '0;
            case (state)
                IDLE: begin
                    if (|pend) begin
                        gnt        <= sel;
                        if (&pend) begin
                            ptr <= ~ptr;
                        end
                        word       <= sel_addr[ADDR_W-1:2];
                        wdata      <= sel_wdata;
                        wmask      <= sel_mask;
                        cnt        <= '0;
                        busy_o     <= '1;
                        ram_addr_o <= {sel_addr[ADDR_W-1:2], 2'b00};
                        if (sel_flag[1]) begin
                            state       <= WR;
                            ram_we_o    <= sel_mask[0];
                            ram_wdata_o <= sel_wdata[7:0];
                        end else begin
                            state    <= RD;
                            ram_we_o <= 1'b0;
                        end
                    end
                end

                RD: begin
                    cnt <= cnt_inc;
                    // ram_rdata_i now carries the byte addressed in the previous cycle.
                    case (cnt)
                        2'd1:    rbuf[7:0]   <= ram_rdata_i;
                        2'd2:    rbuf[15:8]  <= ram_rdata_i;
                        2'd3:    rbuf[23:16] <= ram_rdata_i;
                        default: ;
                    endcase
                    if (cnt == 2'd3) begin
                        state <= RD_TAIL;
                    end else begin
                        ram_addr_o <= {word, cnt_inc};
                    end
                end

                RD_TAIL: begin
                    r_data_o[32*gnt +: 32] <= {ram_rdata_i, rbuf};
                    done_o[gnt]            <= 1'b1;
                    state                  <= DONE;
                end

                WR: begin
                    cnt <= cnt_inc;
                    if (cnt == 2'd3) begin
                        ram_we_o    <= 1'b0;
                        done_o[gnt] <= 1'b1;
                        state       <= DONE;
                    end else begin
                        ram_addr_o  <= {word, cnt_inc};
                        ram_we_o    <= wmask[cnt_inc];
                        ram_wdata_o <= wdata[8*cnt_inc +: 8];
                    end
                end

                DONE: begin
                    busy_o <= '0;
                    state  <= IDLE;
                end

                default: begin
                    state    <= IDLE;
                    busy_o   <= '0;
                    ram_we_o <= 1'b0;
                end
            endcase
        end
    end

    // Structural invariants of the handshake and RAM interface.
    a_done_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(done_o));
    a_we_only_wr:  assert property (@(posedge clk) disable iff (rst) ram_we_o |-> (state == WR));
    a_idle_free:   assert property (@(posedge clk) disable iff (rst) (state == IDLE) |-> (busy_o == '0));

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed vector table, hand-written corner sequences and
// randomized traffic scored against a byte-array memory model with round-robin arbitration.
module tb_mem_ctrl;

    localparam int ADDR_W = 17;
    localparam int MEM_N  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        rw_flag;
    logic [63:0]       addr;
    logic [63:0]       w_data;
    logic [7:0]        w_mask;
    logic [63:0]       r_data;
    logic [1:0]        busy;
    logic [1:0]        done;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(ADDR_W), .PORTS_N(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .rw_flag_i   (rw_flag),
        .addr_i      (addr),
        .w_data_i    (w_data),
        .w_mask_i    (w_mask),
        .r_data_o    (r_data),
        .busy_o      (busy),
        .done_o      (done),
        .ram_addr_o  (ram_addr),
        .ram_we_o    (ram_we),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata)
    );

    // Byte-wide synchronous RAM; read data appears the cycle after the address.
    logic [7:0] ram [MEM_N];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    // Reference model state: expected memory image, per-port read registers, arbitration pointer.
    logic [7:0]  ref_mem [MEM_N];
    logic [31:0] exp_r [2];
    logic        m_ptr;
    int          m_lat;

    int passed = 0;
    int total  = 0;

    typedef struct {
        int          port;
        logic [1:0]  flag;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
        logic [1:0]  e_done;
        int          e_lat;
        logic [63:0] e_r;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    task automatic drive_req(input int p, input logic [1:0] f, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] m);
        rw_flag[2*p +: 2] = f;
        addr[32*p +: 32]  = a;
        w_data[32*p +: 32] = d;
        w_mask[4*p +: 4]  = m;
    endtask

    task automatic clear_req(input int p);
        rw_flag[2*p +: 2] = 2'b00;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        rw_flag = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_r[0] = '0;
        exp_r[1] = '0;
        m_ptr    = 1'b0;
    endtask

    // Counts negedges until a done pulse; cycles after 'skip' must show busy=11.
    task automatic wait_done(input int skip, output logic [1:0] d, output int cyc, output int bb);
        d = '0; cyc = 0; bb = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k > skip && busy !== 2'b11) bb++;
            if (done !== 2'b00) begin
                d   = done;
                cyc = k;
                break;
            end
        end
    endtask

    // Word-level behaviour of one request currently driven on port p.
    task automatic model_apply(input int p);
        logic [ADDR_W-1:0] b;
        b = addr[32*p +: ADDR_W];
        b[1:0] = 2'b00;
        if (rw_flag[2*p+1]) begin
            for (int i = 0; i < 4; i++)
                if (w_mask[4*p+i]) ref_mem[int'(b) + i] = w_data[32*p + 8*i +: 8];
            m_lat = 5;
        end else begin
            exp_r[p] = {ref_mem[int'(b)+3], ref_mem[int'(b)+2], ref_mem[int'(b)+1], ref_mem[int'(b)]};
            m_lat = 6;
        end
    endtask

    task automatic serve(input int p, input int skip, input string name);
        logic [1:0] d;
        int cyc, bb;
        model_apply(p);
        wait_done(skip, d, cyc, bb);
        check({name, "_done"}, {62'd0, d}, 64'd1 << p);
        check({name, "_lat"}, 64'(cyc), 64'(m_lat + skip));
        check({name, "_rdata"}, r_data, {exp_r[1], exp_r[0]});
        check({name, "_busy"}, 64'(bb), 64'd0);
    endtask

    task automatic finish_req(input int p, input string name);
        @(posedge clk);
        #1 clear_req(p);
        @(negedge clk);
        check({name, "_idle_done"}, {62'd0, done}, 64'd0);
        check({name, "_idle_busy"}, {62'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [1:0]  d;
        int          cyc, bb, bad, first;
        logic [31:0] ra;

        tbl[0] = '{0, 2'b01, 32'h0000_0010, 32'h0,         4'h0, 2'b01, 6, {32'h0,        32'h44332211}};
        tbl[1] = '{1, 2'b10, 32'h0000_0020, 32'hAABBCCDD,  4'h5, 2'b10, 5, {32'h0,        32'h44332211}};
        tbl[2] = '{1, 2'b01, 32'h0000_0020, 32'h0,         4'h0, 2'b10, 6, {32'hC3BB5ADD, 32'h44332211}};
        tbl[3] = '{0, 2'b11, 32'h0001_FFFF, 32'h12345678,  4'hF, 2'b01, 5, {32'hC3BB5ADD, 32'h44332211}};
        tbl[4] = '{1, 2'b01, 32'h0001_FFFE, 32'h0,         4'h0, 2'b10, 6, {32'h12345678, 32'h44332211}};
        tbl[5] = '{0, 2'b01, 32'hFFFE_0012, 32'h0,         4'h0, 2'b01, 6, {32'h12345678, 32'h44332211}};
        tbl[6] = '{0, 2'b10, 32'h0000_0010, 32'h99000000,  4'h8, 2'b01, 5, {32'h12345678, 32'h44332211}};
        tbl[7] = '{0, 2'b01, 32'h0000_0011, 32'h0,         4'h0, 2'b01, 6, {32'h12345678, 32'h99332211}};

        for (int i = 0; i < MEM_N; i++) begin
            ram[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        ram[16'h10] = 8'h11; ram[16'h11] = 8'h22; ram[16'h12] = 8'h33; ram[16'h13] = 8'h44;
        ram[16'h21] = 8'h5A; ram[16'h23] = 8'hC3;
        for (int i = 16'h40; i < 16'h44; i++) ram[i] = 8'hEE;
        for (int i = 0; i < 16'h50; i++) ref_mem[i] = ram[i];

        // Reset dominates even with requests pending.
        rst = 1'b1;
        rw_flag = 4'b0101; addr = '0; w_data = '0; w_mask = '0;
        exp_r[0] = '0; exp_r[1] = '0; m_ptr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {62'd0, busy}, 64'd0);
        check("rst_done", {62'd0, done}, 64'd0);
        check("rst_rdata", r_data, 64'd0);
        check("rst_we", {63'd0, ram_we}, 64'd0);
        check("rst_addr", 64'(ram_addr), 64'd0);
        check("rst_wdata", {56'd0, ram_wdata}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        rw_flag = '0;

        // Directed vector table: single requests, one at a time.
        for (int i = 0; i < 8; i++) begin
            drive_req(tbl[i].port, tbl[i].flag, tbl[i].a, tbl[i].d, tbl[i].m);
            @(posedge clk);
            model_apply(tbl[i].port);
            wait_done(0, d, cyc, bb);
            check($sformatf("vec%0d_done", i), {62'd0, d}, {62'd0, tbl[i].e_done});
            check($sformatf("vec%0d_lat", i), 64'(cyc), 64'(tbl[i].e_lat));
            check($sformatf("vec%0d_rdata", i), r_data, tbl[i].e_r);
            check($sformatf("vec%0d_busy", i), 64'(bb), 64'd0);
            finish_req(tbl[i].port, $sformatf("vec%0d", i));
        end

        // Simultaneous reads alternate: p0,p1 then p1,p0.
        do_reset();
        drive_req(0, 2'b01, 32'h10, 32'h0, 4'h0);
        drive_req(1, 2'b01, 32'h20, 32'h0, 4'h0);
        @(posedge clk);
        serve(0, 0, "t3_pair1_p0");
        @(posedge clk); #1 clear_req(0);
        serve(1, 1, "t3_pair1_p1");
        finish_req(1, "t3_pair1");
        drive_req(0, 2'b01, 32'h20, 32'h0, 4'h0);
        drive_req(1, 2'b01, 32'h10, 32'h0, 4'h0);
        @(posedge clk);
        serve(1, 0, "t3_pair2_p1");
        @(posedge clk); #1 clear_req(1);
        serve(0, 1, "t3_pair2_p0");
        finish_req(0, "t3_pair2");

        // Reset takes effect from cycle 3 of a full-mask write: only bytes 0-1 land.
        drive_req(0, 2'b10, 32'h40, 32'h01020304, 4'hF);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        clear_req(0);
        exp_r[0] = '0; exp_r[1] = '0; m_ptr = 1'b0;
        ref_mem[16'h40] = 8'h04;
        ref_mem[16'h41] = 8'h03;
        @(negedge clk);
        check("t4_busy", {62'd0, busy}, 64'd0);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (done !== 2'b00) bad++;
            @(negedge clk);
        end
        check("t4_no_done", 64'(bad), 64'd0);
        check("t4_ram", {32'd0, ram[16'h43], ram[16'h42], ram[16'h41], ram[16'h40]}, 64'h0000_0000_EEEE_0304);
        drive_req(1, 2'b01, 32'h40, 32'h0, 4'h0);
        @(posedge clk);
        serve(1, 0, "t4_next");
        finish_req(1, "t4_next");

        // Flag held through done: the same read is accepted again.
        drive_req(0, 2'b01, 32'h10, 32'h0, 4'h0);
        @(posedge clk);
        serve(0, 0, "t6_first");
        serve(0, 1, "t6_again");
        finish_req(0, "t6");

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int p = 0; p < 2; p++) begin
                    ra = ($urandom & 32'hFFFE_0000) | (32'h100 + 32'($urandom_range(0, 63)));
                    drive_req(p, 2'($urandom_range(1, 3)), ra, $urandom, 4'($urandom_range(0, 15)));
                end
                @(posedge clk);
                first = int'(m_ptr);
                m_ptr = ~m_ptr;
                serve(first, 0, $sformatf("rnd%0d_a", n));
                @(posedge clk); #1 clear_req(first);
                serve(1 - first, 1, $sformatf("rnd%0d_b", n));
                finish_req(1 - first, $sformatf("rnd%0d", n));
            end else begin
                first = int'($urandom_range(0, 1));
                ra = ($urandom & 32'hFFFE_0000) | (32'h100 + 32'($urandom_range(0, 63)));
                drive_req(first, 2'($urandom_range(1, 3)), ra, $urandom, 4'($urandom_range(0, 15)));
                @(posedge clk);
                serve(first, 0, $sformatf("rnd%0d", n));
                finish_req(first, $sformatf("rnd%0d", n));
            end
        end

        bad = 0;
        for (int i = 0; i < MEM_N; i++)
            if (ram[i] !== ref_mem[i]) bad++;
        check("mem_image", 64'(bad), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
